// File: rtl/shift_add_mult32.sv
// shift_add_mult32: sequential 32x32 unsigned multiplier built on adder32.
//
// A 32-iteration shift-add loop. Every RUN cycle the adder adds the
// multiplicand (or zero, depending on the multiplier's current LSB) to the
// accumulator. The full 33-bit sum is shifted right by one into the
// {hi, lo} pair, so the adder's carry-out becomes the top bit of hi.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   start      in   1   request, accepted only on an edge where ready=1
//   a_in       in   32  multiplicand, sampled on the accepting edge
//   b_in       in   32  multiplier, sampled on the accepting edge
//   ready      out  1   high in IDLE only
//   busy       out  1   high in RUN only
//   valid_out  out  1   one-cycle pulse in DONE
//   product    out  64  registered result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start; operands are sampled on the accepting edge
// RUN   | one shift-add iteration per edge, 32 in total (cnt 0..31)
// DONE  | product was just loaded; valid_out pulses for this one cycle

// adder32: combinational 32-bit unsigned adder with carry-out in sum[32].
//   a    in   32  addend
//   b    in   32  addend
//   sum  out  33  a + b, including the carry-out
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [32:0] sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

module shift_add_mult32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        ready,
    output logic        busy,
    output logic        valid_out,
    output logic [63:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  cnt;
    logic [31:0] add_b;
    logic [32:0] sum;

    assign add_b = lo[0] ? mcand : 32'd0;

    adder32 u_adder (
        .a   (hi),
        .b   (add_b),
        .sum (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        valid_out  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_out  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= 5'd0;
            product <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_in;
                        lo    <= b_in;
                        hi    <= 32'd0;
                        cnt   <= 5'd0;
                    end
                end
                RUN: begin
                    hi  <= sum[32:1];
                    lo  <= {sum[0], lo[31:1]};
                    cnt <= cnt + 5'd1;
                    // Last iteration: capture the post-shift {hi, lo} directly
                    // from the adder so product is final on this same edge.
                    if (cnt == 5'd31) begin
                        product <= {sum[32:1], sum[0], lo[31:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult32.sv
module tb_shift_add_mult32;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        busy;
    logic        valid_out;
    logic [63:0] product;

    int n_cmp;
    int n_bad;

    shift_add_mult32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready     (ready),
        .busy      (busy),
        .valid_out (valid_out),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain 64-bit unsigned multiply.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    // Accept one operation from IDLE and follow it to completion.
    // poke_at >= 0 pulses start with new operands at that iteration count.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag, input int poke_at);
        int          n;
        int          pulses;
        logic        stable;
        logic [63:0] prev;
        @(negedge clk);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
        n      = 0;
        pulses = 0;
        stable = 1'b1;
        prev   = product;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke_at) begin
                a_in  = 32'd1;
                b_in  = 32'd1;
                start = 1'b1;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (valid_out) break;
            if (product !== prev) stable = 1'b0;
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_product"}, product, ref_mul(x, y));
        check({tag, "_no_partial"}, {63'd0, stable}, 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_ready_after"}, {62'd0, ready, valid_out}, 64'd2);
        if (poke_at >= 0) begin
            pulses = 1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (valid_out) pulses++;
            end
            check({tag, "_one_pulse"}, 64'(pulses), 64'd1);
        end
    endtask

    initial begin
        int          n;
        int          t1;
        int          t2;
        int          seen;
        logic [63:0] p1;
        logic [63:0] p2;
        logic [31:0] rx;
        logic [31:0] ry;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {product[63:60], 57'd0, ready, busy, valid_out}, 64'd4);
        check("reset_product", product, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, "p3x5", -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "pmax", -1);
        run_op(32'h8000_0000, 32'd2, "pmsb", -1);
        run_op(32'd0, 32'h1234_5678, "pzero", -1);
        run_op(32'd7, 32'd9, "pignore", 10);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a_in  = 32'd6;
        b_in  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_state", {61'd0, ready, busy, valid_out}, 64'd4);
        check("rst_mid_product", product, 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_out) seen++;
        end
        check("rst_no_valid", 64'(seen), 64'd0);
        run_op(32'd6, 32'd7, "p6x7", -1);

        // start held high: back-to-back operations.
        @(negedge clk);
        a_in  = 32'd10;
        b_in  = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in = 32'd11;
        b_in = 32'd11;
        n    = 0;
        seen = 0;
        t1   = -1;
        t2   = -1;
        p1   = '0;
        p2   = '0;
        while (n < 120 && seen < 2) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_out) begin
                seen++;
                if (seen == 1) begin
                    t1 = n;
                    p1 = product;
                end else begin
                    t2 = n;
                    p2 = product;
                end
            end
        end
        start = 1'b0;
        check("held_pulses", 64'(seen), 64'd2);
        check("held_first_time", 64'(t1), 64'd32);
        check("held_spacing", 64'(t2 - t1), 64'd34);
        check("held_p1", p1, 64'd100);
        check("held_p2", p2, 64'd121);
        repeat (40) @(posedge clk);

        for (int k = 0; k < 20; k++) begin
            rx = $urandom;
            ry = $urandom;
            if (k == 0) ry = 32'd0;
            if (k == 1) rx = 32'd1;
            run_op(rx, ry, $sformatf("rand%0d", k), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
